// File: rtl/ex_alu_dpath_arb.sv
// ex_alu_dpath_arb
// Shares one ALU datapath (adder/shifter/logic) between four requesters:
// 0 = rglr, 1 = bjp, 2 = agu, 3 = mdv. Single-cycle ops are granted
// round-robin and combinationally, so an op completes in the cycle it is
// granted. A requester can lock the datapath across cycles; a watchdog
// forces the lock free after MAX_LOCK consecutive locked cycles.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid[3:0]       per-requester request
//   req_ready[3:0]       per-requester grant, one-hot or zero (combinational)
//   req_lock[3:0]        keep the datapath after this handshake
//   req_op[i]            one-hot op per requester (passed through unchecked)
//   req_op1/req_op2[i]   operands per requester
//   dp_valid/op/op1/op2  granted op and operands, zero when nothing granted
//   dp_res               combinational datapath result
//   res                  dp_res broadcast; a requester qualifies it with its ready
//   locked, lock_owner   registered lock state and owner index
//   lock_err             one-cycle pulse after a watchdog forced release
module ex_alu_dpath_arb #(
    parameter int XLEN     = 32,
    parameter int OPW      = 11,
    parameter int MAX_LOCK = 40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                req_valid,
    output logic [3:0]                req_ready,
    input  logic [3:0]                req_lock,
    input  logic [3:0][OPW-1:0]       req_op,
    input  logic [3:0][XLEN-1:0]      req_op1,
    input  logic [3:0][XLEN-1:0]      req_op2,
    output logic                      dp_valid,
    output logic [OPW-1:0]            dp_op,
    output logic [XLEN-1:0]           dp_op1,
    output logic [XLEN-1:0]           dp_op2,
    input  logic [XLEN-1:0]           dp_res,
    output logic [XLEN-1:0]           res,
    output logic                      locked,
    output logic [1:0]                lock_owner,
    output logic                      lock_err
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_r;
    logic [1:0]      rr_ptr_r;
    logic [1:0]      owner_r;
    logic [CW-1:0]   lock_cnt_r;
    logic            lock_err_r;

    logic [7:0]      rot8_s;
    logic [3:0]      rot_s;
    logic [1:0]      off_s;
    logic [1:0]      grant_idx_s;
    logic [3:0]      grant_s;
    logic            hs_s;
    logic            rel_s;
    logic            wd_s;
    logic [OPW-1:0]  mux_op_s;
    logic [XLEN-1:0] mux_op1_s;
    logic [XLEN-1:0] mux_op2_s;

    // Grant selection: rotated priority scan in IDLE, owner-only while LOCKED.
    always_comb begin
        // Bit k of rot_s is the request at index rr_ptr+k (mod 4).
        rot8_s      = {req_valid, req_valid} >> rr_ptr_r;
        rot_s       = rot8_s[3:0];
        off_s       = 2'd0;
        grant_idx_s = 2'd0;
        grant_s     = 4'b0000;
        if (rot_s[0]) begin
            off_s = 2'd0;
        end else if (rot_s[1]) begin
            off_s = 2'd1;
        end else if (rot_s[2]) begin
            off_s = 2'd2;
        end else begin
            off_s = 2'd3;
        end
        case (state_r)
            ST_IDLE: begin
                grant_idx_s = rr_ptr_r + off_s;
                if (|req_valid) begin
                    grant_s = 4'b0001 << grant_idx_s;
                end else begin
                    grant_s = 4'b0000;
                end
            end
            ST_LOCKED: begin
                grant_idx_s = owner_r;
                if (req_valid[owner_r]) begin
                    grant_s = 4'b0001 << owner_r;
                end else begin
                    grant_s = 4'b0000;
                end
            end
            default: begin
                grant_idx_s = 2'd0;
                grant_s     = 4'b0000;
            end
        endcase
    end

    // A grant is only ever given to a valid requester, so any grant is a handshake.
    assign hs_s  = |grant_s;
    assign rel_s = (state_r == ST_LOCKED) && hs_s && !req_lock[owner_r];
    // A release handshake in the limit cycle takes precedence over the watchdog.
    assign wd_s  = (state_r == ST_LOCKED) && (lock_cnt_r == CW'(MAX_LOCK - 1)) && !rel_s;

    // AND-OR datapath mux; ungranted lanes contribute zero so idle outputs stay quiet.
    always_comb begin
        mux_op_s  = '0;
        mux_op1_s = '0;
        mux_op2_s = '0;
        for (int i = 0; i < 4; i++) begin
            mux_op_s  = mux_op_s  | (req_op[i]  & {OPW{grant_s[i]}});
            mux_op1_s = mux_op1_s | (req_op1[i] & {XLEN{grant_s[i]}});
            mux_op2_s = mux_op2_s | (req_op2[i] & {XLEN{grant_s[i]}});
        end
    end

    // Lock FSM, round-robin pointer, watchdog counter and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= 2'd0;
            owner_r    <= 2'd0;
            lock_cnt_r <= '0;
            lock_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    lock_err_r <= 1'b0;
                    if (hs_s) begin
                        rr_ptr_r <= grant_idx_s + 2'd1;
                        if (req_lock[grant_idx_s]) begin
                            state_r    <= ST_LOCKED;
                            owner_r    <= grant_idx_s;
                            lock_cnt_r <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rel_s) begin
                        state_r    <= ST_IDLE;
                        rr_ptr_r   <= owner_r + 2'd1;
                        lock_cnt_r <= '0;
                        lock_err_r <= 1'b0;
                    end else if (wd_s) begin
                        state_r    <= ST_IDLE;
                        rr_ptr_r   <= owner_r + 2'd1;
                        lock_cnt_r <= '0;
                        lock_err_r <= 1'b1;
                    end else begin
                        lock_err_r <= 1'b0;
                        if (lock_cnt_r != CW'(MAX_LOCK)) begin
                            lock_cnt_r <= lock_cnt_r + CW'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    lock_cnt_r <= '0;
                    lock_err_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = grant_s;
    assign dp_valid   = hs_s;
    assign dp_op      = mux_op_s;
    assign dp_op1     = mux_op1_s;
    assign dp_op2     = mux_op2_s;
    assign res        = dp_res;
    assign locked     = (state_r == ST_LOCKED);
    assign lock_owner = owner_r;
    assign lock_err   = lock_err_r;

endmodule

// File: doc/ex_alu_dpath_arb.md
# ex_alu_dpath_arb

Arbiter and sequencer for the shared ALU datapath in the EXU. It shares one adder/shifter/logic datapath between four requesters: regular ALU, BJP, AGU and MDV. Single-cycle operations are granted round-robin. A multi-cycle requester (AGU misaligned split, MDV iteration) can lock the datapath across cycles, and a watchdog releases locks that are held too long. The grant is combinational from the valid inputs, so a single-cycle op completes in the cycle it is granted. Lock and pointer state are registered.

## Interface
Parameters:
- XLEN, 32, operand/result width
- OPW, 11, one-hot op vector width (add, sub, xor, sll, srl, sra, or, and, slt, sltu, lui)
- MAX_LOCK, 40, maximum consecutive LOCKED cycles before forced release (must be ≥2)

Ports (requester index i: 0 = rglr, 1 = bjp, 2 = agu, 3 = mdv):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  4  per-requester request
- req_ready  out  4  per-requester grant; one-hot or zero
- req_lock  in  4  requester i asks to keep the datapath after this handshake
- req_op  in  4×OPW  one-hot op per requester
- req_op1, req_op2  in  4×XLEN  operands per requester
- dp_valid  out  1  datapath carries a granted op this cycle
- dp_op  out  OPW  granted op; zero when !dp_valid
- dp_op1, dp_op2  out  XLEN  granted operands; zero when !dp_valid
- dp_res  in  XLEN  combinational datapath result
- res  out  XLEN  dp_res broadcast; qualified by req_ready[i]
- locked  out  1  registered LOCKED state
- lock_owner  out  2  registered owner index; meaningful only while locked
- lock_err  out  1  one-cycle pulse on watchdog forced release

## Operation
- **State:**
  - FSM with states IDLE and LOCKED.
  - rr_ptr (2 bits): the highest-priority index.
  - owner (2 bits).
  - lock_cnt: ceil(log2(MAX_LOCK+1)) bits.
- **IDLE grant:**
  - Scan req_valid starting at rr_ptr, ascending mod 4; the first set bit gets req_ready.
  - If no request is valid: req_ready = 0 and dp_valid = 0.
- **Handshake** = req_valid[i] & req_ready[i].
- **IDLE on handshake by i:**
  - rr_ptr ← (i+1) mod 4.
  - If req_lock[i] is high, the FSM moves to LOCKED with owner ← i and lock_cnt ← 0.
- **LOCKED grant:**
  - req_ready = req_valid[owner] only; every other requester is stalled even if valid.
  - If owner is not valid, dp_valid = 0 and the state is held.
- **LOCKED, each cycle:** lock_cnt increments, saturating at MAX_LOCK.
- **LOCKED release:**
  - Trigger: owner handshakes with req_lock[owner] = 0.
  - Result: IDLE, rr_ptr ← owner+1, lock_cnt ← 0.
  - An owner handshake with lock high stays LOCKED.
- **Watchdog:**
  - Trigger: LOCKED, lock_cnt = MAX_LOCK−1, and no release handshake this cycle.
  - Result: IDLE next cycle, lock_err = 1 for that one cycle, rr_ptr ← owner+1.
- **Simultaneous release handshake and watchdog limit:** normal release wins; lock_err stays 0.
- **Datapath mux:** AND-OR one-hot mux of req_op/op1/op2 by req_ready. The zero-gated outputs save toggle power.
- **Malformed op:** a req_op with more than one bit set is passed through unchanged; the arbiter does not check it.
- **Reset values:**
  - State IDLE, rr_ptr = 0, owner = 0, lock_cnt = 0.
  - locked = 0, lock_owner = 0, lock_err = 0.
  - req_ready and dp_* follow IDLE combinational rules, so they are zero with no valid input.
- **Reset mid-lock:** immediately returns to IDLE; lock_err is not asserted.

## Timing
- Grant latency is 0 cycles: req_valid → req_ready → dp_* → res, all within one cycle. No register sits in the data path.
- A single-cycle op completes in the cycle it is granted.
- A requester must hold its valid, op and operands stable until it receives ready.
- After a lock is granted, lock takes effect from the next cycle. locked rises one cycle after the locking handshake.
- Release is also effective from the next cycle: another requester can be granted in the cycle after the unlocking handshake.
- lock_err is registered and aligns with the first IDLE cycle after a forced release.

## Test plan
1. **Reset and idle.** Reset, then all valid = 0 → req_ready = 0, dp_valid = 0, dp_op1 = 0, locked = 0, lock_err = 0.
2. **Round-robin.**
   - Stimulus: all four valid for 8 cycles, no lock, ops add with op1 = i, op2 = 1.
   - Grants: 0, 1, 2, 3, 0, 1, 2, 3.
   - Datapath: dp_op1 = granted index each cycle, and res = dp_res.
3. **Lock hold.**
   - mdv (3) handshakes with lock = 1 while rglr (0) is valid continuously.
   - mdv stays valid with lock = 1 for 5 cycles, then lock = 0.
   - rglr remains stalled throughout.
   - rglr is granted in the cycle after mdv's unlocking handshake, with rr_ptr = 0.
4. **Owner gap.** While locked to agu (2), agu valid drops for 3 cycles → dp_valid = 0, req_ready = 0 for bjp even though bjp is valid, locked stays 1.
5. **Watchdog (MAX_LOCK = 4).**
   - bjp locks and keeps lock = 1.
   - Forced release happens after 4 LOCKED cycles: lock_err pulses for exactly 1 cycle, locked = 0.
   - The next grant goes to agu if agu is valid.
   - Variant: bjp releases normally in the limit cycle → no lock_err.
6. **Reset while LOCKED.** Assert rst mid-lock → locked = 0 immediately (asynchronous), rr_ptr = 0, no lock_err. After deassertion, with all valid, requester 0 is granted first.
